dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/rv32i_types.sv | 10 +
 rtl/dmem_lfsr.sv | 24 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder: FSM state encoding and LFSR seed.
package rv32i_types;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [15:0] DMEM_LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/dmem_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used to add random stall cycles.
module dmem_lfsr
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  always_comb begin
    feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = {feedback, lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= DMEM_LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;
endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed wait states and a sticky error flag.
// Optional random stalls are enabled by defining DMEM_STALL_EN.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 5;

  dmem_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         ofs_q, ofs_d;
  logic [3:0]         rmask_q, rmask_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        mem_rd_q;
  logic [IDX_W-1:0]   rd_idx;
  logic [CNT_W-1:0]   wait_load;
  logic               req_valid;
  logic               bad_req;
  logic               addr_unused;

  assign addr_unused = ^dmem_addr[31:2+IDX_W];

`ifdef DMEM_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;

  dmem_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:2];
  assign wait_load   = CNT_W'(WAIT_CYCLES) + {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
  assign wait_load   = CNT_W'(WAIT_CYCLES);
`endif

  assign req_valid = (|dmem_rmask) | (|dmem_wmask);
  // Conflicting masks or a misaligned address turn the request into a no-access response.
  assign bad_req   = ((|rmask_q) && (|wmask_q)) || (ofs_q != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ofs_d   = ofs_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = dmem_addr[2 +: IDX_W];
          ofs_d   = dmem_addr[1:0];
          rmask_d = dmem_rmask;
          wmask_d = dmem_wmask;
          wdata_d = dmem_wdata;
          cnt_d   = wait_load;
          state_d = (wait_load != '0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (bad_req) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ofs_q   <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ofs_q   <= ofs_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // In IDLE the read port follows the live address so a zero-wait read is ready in RESP.
  assign rd_idx = (state_q == IDLE) ? dmem_addr[2 +: IDX_W] : idx_q;

  always_ff @(posedge clk) begin
    mem_rd_q <= mem[rd_idx];
    if (state_q == RESP && !bad_req) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign dmem_ready = (state_q == IDLE);
  assign dmem_resp  = (state_q == RESP);
  assign dmem_rdata = (state_q == RESP && (|rmask_q) && !bad_req) ? mem_rd_q : 32'h0;
  assign dmem_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (default build, WAIT_CYCLES=1).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb_q[$];
  logic        err_exp = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .dmem_err   (dmem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
  endtask

  // One request; exp_rd is the rdata expected in the RESP cycle.
  task automatic txn(input string tag, input logic [31:0] addr, input logic [3:0] rm,
                     input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input bit exp_bad, input bit inject);
    int n;
    logic [31:0] e;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, dmem_ready}, 32'd1);
    dmem_addr  = addr;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    sb_q.push_back(exp_rd);
    @(negedge clk);
    if (inject) begin
      dmem_addr  = 32'h40;
      dmem_rmask = 4'h0;
      dmem_wmask = 4'hF;
      dmem_wdata = 32'hFFFF_FFFF;
    end else begin
      idle_inputs();
    end
    check({tag, "_busy"}, {31'b0, dmem_ready}, 32'd0);
    n = 1;
    while (dmem_resp !== 1'b1 && n < 20) begin
      @(negedge clk);
      idle_inputs();
      n++;
    end
    idle_inputs();
    check({tag, "_latency"}, 32'(n), 32'd2);
    e = sb_q.pop_front();
    check({tag, "_rdata"}, dmem_rdata, e);
    check({tag, "_err_in_resp"}, {31'b0, dmem_err}, {31'b0, err_exp});
    if (exp_bad) err_exp = 1'b1;
    @(negedge clk);
    check({tag, "_resp_pulse"}, {31'b0, dmem_resp}, 32'd0);
    check({tag, "_rdata_idle"}, dmem_rdata, 32'd0);
    check({tag, "_err_after"}, {31'b0, dmem_err}, {31'b0, err_exp});
  endtask

  initial begin
    #2;
    check("rst_ready", {31'b0, dmem_ready}, 32'd1);
    check("rst_resp", {31'b0, dmem_resp}, 32'd0);
    check("rst_rdata", dmem_rdata, 32'd0);
    check("rst_err", {31'b0, dmem_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    txn("w_full", 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    txn("r_full", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    txn("w_byte", 32'h10, 4'h0, 4'h1, 32'h000000AA, 32'h0, 1'b0, 1'b0);
    txn("r_byte", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 1'b0);
    txn("w_14", 32'h14, 4'h0, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b0);
    txn("w_half", 32'h14, 4'h0, 4'h6, 32'h00BEEF00, 32'h0, 1'b0, 1'b0);
    txn("r_half", 32'h14, 4'h3, 4'h0, 32'h0, 32'h11BEEF44, 1'b0, 1'b0);
    txn("w_wrap", 32'h1018, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    txn("r_wrap", 32'h18, 4'hF, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    txn("w_40", 32'h40, 4'h0, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, 1'b0);
    txn("r_40_inj", 32'h40, 4'hF, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, 1'b1);
    txn("r_40_after", 32'h40, 4'hF, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, 1'b0);
    txn("w_20", 32'h20, 4'h0, 4'hF, 32'h01020304, 32'h0, 1'b0, 1'b0);
    txn("r_misalign", 32'h12, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    txn("rw_conflict", 32'h20, 4'h3, 4'h1, 32'h000000FF, 32'h0, 1'b1, 1'b0);
    txn("r_20_after", 32'h20, 4'hF, 4'h0, 32'h0, 32'h01020304, 1'b0, 1'b0);
    txn("w_30", 32'h30, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    txn("r_30", 32'h30, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    // Abandon a write by resetting while it sits in WAIT.
    @(negedge clk);
    dmem_addr  = 32'h30;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    idle_inputs();
    check("wait_before_rst", {31'b0, dmem_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, dmem_ready}, 32'd1);
    check("rst_mid_resp", {31'b0, dmem_resp}, 32'd0);
    check("rst_mid_rdata", dmem_rdata, 32'd0);
    check("rst_mid_err", {31'b0, dmem_err}, 32'd0);
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    txn("r_30_kept", 32'h30, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
    txn("r_10_kept", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
